// File: rtl/add_round_key_if.sv
// Bus between the AES round datapath/key schedule and the AddRoundKey sequencer.
// The slave modport is the sequencer; the master modport is its environment.
interface add_round_key_if #(
    parameter int ROUND_W = 4
);
    logic                  start;
    logic [15:0][7:0]      text_in;
    logic [15:0][7:0]      text_mc;
    logic [15:0][7:0]      round_key;
    logic                  rk_valid;
    logic [ROUND_W-1:0]    rk_round;
    logic                  enbmc;
    logic [15:0][7:0]      state_out;
    logic                  busy;
    logic                  done;

    modport master (
        output start, text_in, text_mc, round_key, rk_valid,
        input  rk_round, enbmc, state_out, busy, done
    );

    modport slave (
        input  start, text_in, text_mc, round_key, rk_valid,
        output rk_round, enbmc, state_out, busy, done
    );
endinterface

// File: rtl/add_round_key_ctrl.sv
// AddRoundKey stage and round sequencer of the SISO AES encoder: owns the state
// register feeding SubBytes, XORs each round result with its key, drives MixColumns bypass.
module add_round_key_ctrl #(
    parameter int NR      = 10,
    parameter int ROUND_W = 4
) (
    input  logic           clk,
    input  logic           rst,
    add_round_key_if.slave bus,
    output logic [1:0]     fsm_state
);

    // Handshake: start is a request sampled only in IDLE (ignored otherwise);
    // rk_valid qualifies round_key for rk_round, and a step (ARK0 or one round)
    // completes only on a cycle where it is high, otherwise everything holds;
    // done is a single-cycle pulse with the ciphertext on state_out.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARK0 = 2'd1,
        RND  = 2'd2,
        DONE = 2'd3
    } fsm_e;

    fsm_e               state_q, state_d;
    logic [15:0][7:0]   text_q, text_d;
    logic [ROUND_W-1:0] round_q, round_d;
    logic               last_round;

    assign last_round = (round_q == ROUND_W'(NR));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            text_q  <= '0;
            round_q <= '0;
        end else begin
            state_q <= state_d;
            text_q  <= text_d;
            round_q <= round_d;
        end
    end

    always_comb begin
        state_d = state_q;
        text_d  = text_q;
        round_d = round_q;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    text_d  = bus.text_in;
                    round_d = '0;
                    state_d = ARK0;
                end
            end
            ARK0: begin
                if (bus.rk_valid) begin
                    text_d  = text_q ^ bus.round_key;
                    round_d = ROUND_W'(1);
                    state_d = RND;
                end
            end
            RND: begin
                if (bus.rk_valid) begin
                    text_d = bus.text_mc ^ bus.round_key;
                    // Index saturates at NR so the key schedule keeps seeing the last key.
                    if (last_round) begin
                        state_d = DONE;
                    end else begin
                        round_d = round_q + ROUND_W'(1);
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.state_out = text_q;
    assign bus.rk_round  = round_q;
    assign bus.enbmc     = !((state_q == RND) && last_round);
    assign bus.busy      = (state_q != IDLE);
    assign bus.done      = (state_q == DONE);
    assign fsm_state     = state_q;

endmodule

// File: tb/tb_add_round_key_ctrl.sv
// Bench for add_round_key_ctrl: an AES round/key-schedule environment around the DUT,
// directed FIPS-197 vectors, and a done-triggered scoreboard checking ciphertext and timing.
module tb_add_round_key_ctrl;

    typedef logic [15:0][7:0] blk_t;

    localparam logic [127:0] KEY1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] PT1  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CT1  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] KEY2 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PT2  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT2  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] PTX  = 128'hdeadbeef00112233445566778899aabb;

    logic       clk;
    logic       rst;
    logic [1:0] fsm_state;
    int         cyc;
    int         checks;
    int         failures;
    blk_t       rks [16];

    logic [127:0] exp_q[$];
    int           exp_cyc_q[$];

    add_round_key_if #(.ROUND_W(4)) bus ();

    add_round_key_ctrl #(.NR(10), .ROUND_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus.slave),
        .fsm_state (fsm_state)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- AES environment ----------------
    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xt(x);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        return (x << n) | (x >> (8 - n));
    endfunction

    // S-box from first principles: inverse as a^254, then the affine map.
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] sq;
        logic [7:0] inv;
        sq  = a;
        inv = 8'h01;
        for (int k = 1; k < 8; k++) begin
            sq  = gmul(sq, sq);
            inv = gmul(inv, sq);
        end
        return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    endfunction

    function automatic blk_t aes_round(input blk_t s, input logic mc);
        blk_t b;
        blk_t o;
        logic [7:0] a0, a1, a2, a3;
        for (int i = 0; i < 16; i++) b[i] = sbox(s[i]);
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                o[r + 4 * c] = b[r + 4 * ((c + r) % 4)];
        if (mc) begin
            for (int c = 0; c < 4; c++) begin
                a0 = o[4 * c]; a1 = o[4 * c + 1]; a2 = o[4 * c + 2]; a3 = o[4 * c + 3];
                o[4 * c]     = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
                o[4 * c + 1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
                o[4 * c + 2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
                o[4 * c + 3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
            end
        end
        return o;
    endfunction

    function automatic blk_t to_bytes(input logic [127:0] v);
        blk_t b;
        for (int i = 0; i < 16; i++) b[i] = v[127 - 8 * i -: 8];
        return b;
    endfunction

    function automatic logic [127:0] from_bytes(input blk_t b);
        logic [127:0] v;
        for (int i = 0; i < 16; i++) v[127 - 8 * i -: 8] = b[i];
        return v;
    endfunction

    // State after the initial AddRoundKey and n full rounds.
    function automatic blk_t ref_state(input blk_t pt, input int n);
        blk_t s;
        s = pt ^ rks[0];
        for (int r = 1; r <= n; r++) s = aes_round(s, r != 10) ^ rks[r];
        return s;
    endfunction

    task automatic load_key(input logic [127:0] key);
        logic [7:0] w [176];
        logic [7:0] t0, t1, t2, t3, tmp, rcon;
        rcon = 8'h01;
        for (int i = 0; i < 16; i++) w[i] = key[127 - 8 * i -: 8];
        for (int i = 16; i < 176; i += 4) begin
            t0 = w[i - 4]; t1 = w[i - 3]; t2 = w[i - 2]; t3 = w[i - 1];
            if (i % 16 == 0) begin
                tmp  = t0;
                t0   = sbox(t1) ^ rcon;
                t1   = sbox(t2);
                t2   = sbox(t3);
                t3   = sbox(tmp);
                rcon = xt(rcon);
            end
            w[i]     = w[i - 16] ^ t0;
            w[i + 1] = w[i - 15] ^ t1;
            w[i + 2] = w[i - 14] ^ t2;
            w[i + 3] = w[i - 13] ^ t3;
        end
        for (int r = 0; r < 16; r++)
            for (int j = 0; j < 16; j++)
                rks[r][j] = (r <= 10) ? w[16 * r + j] : 8'h00;
    endtask

    assign bus.text_mc   = aes_round(bus.state_out, bus.enbmc);
    assign bus.round_key = rks[bus.rk_round];

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%h exp=%h", name, act, exp);
        end
    endtask

    task automatic check_n(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s act=%0d exp=%0d", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst && bus.done) begin
            if (exp_q.size() == 0) begin
                check_n("sb_unexpected_done", 1, 0);
            end else begin
                check("sb_ciphertext", from_bytes(bus.state_out), exp_q.pop_front());
                check_n("sb_done_cycle", cyc, exp_cyc_q.pop_front());
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic start_enc(input logic [127:0] pt, input logic [127:0] ct,
                             input bit expect_done, input int stall);
        bus.text_in = to_bytes(pt);
        bus.start   = 1'b1;
        if (expect_done) begin
            exp_q.push_back(ct);
            exp_cyc_q.push_back(cyc + 12 + stall);
        end
        tick(1);
        bus.start = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (bus.busy && n < budget) begin
            tick(1);
            n++;
        end
        check_n("idle_timeout", int'(bus.busy), 0);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_state"}, from_bytes(bus.state_out), 128'h0);
        check_n({tag, "_round"}, int'(bus.rk_round), 0);
        check_n({tag, "_busy"}, int'(bus.busy), 0);
        check_n({tag, "_done"}, int'(bus.done), 0);
        check_n({tag, "_enbmc"}, int'(bus.enbmc), 1);
        check_n({tag, "_fsm"}, int'(fsm_state), 0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int   exp_round;
        blk_t mid;
        cyc         = 0;
        checks      = 0;
        failures    = 0;
        rst         = 1'b1;
        bus.start   = 1'b0;
        bus.rk_valid = 1'b1;
        bus.text_in = '0;
        load_key(KEY1);
        tick(3);
        check_reset_values("reset");
        rst = 1'b0;
        tick(2);

        // FIPS-197 App.B with rk_valid high; walk the round index and MixColumns bypass.
        start_enc(PT1, CT1, 1'b1, 0);
        check("ark0_loaded", from_bytes(bus.state_out), PT1);
        for (int i = 1; i <= 12; i++) begin
            exp_round = (i == 1) ? 0 : ((i <= 11) ? i - 1 : 10);
            check_n("walk_round", int'(bus.rk_round), exp_round);
            check_n("walk_enbmc", int'(bus.enbmc), (i == 11) ? 0 : 1);
            check_n("walk_busy", int'(bus.busy), 1);
            tick(1);
        end
        check_n("after_done_busy", int'(bus.busy), 0);
        wait_idle(5);

        // FIPS-197 App.C.1 under a different key.
        load_key(KEY2);
        tick(1);
        start_enc(PT2, CT2, 1'b1, 0);
        wait_idle(20);
        load_key(KEY1);
        tick(2);

        // Stalls: 3 cycles in ARK0, 2 cycles at round 5.
        bus.rk_valid = 1'b0;
        start_enc(PT1, CT1, 1'b1, 5);
        for (int i = 0; i < 3; i++) begin
            check("stall0_state", from_bytes(bus.state_out), PT1);
            check_n("stall0_round", int'(bus.rk_round), 0);
            tick(1);
        end
        bus.rk_valid = 1'b1;
        tick(5);
        mid = ref_state(to_bytes(PT1), 4);
        check_n("stall5_round", int'(bus.rk_round), 5);
        check("stall5_state", from_bytes(bus.state_out), from_bytes(mid));
        bus.rk_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick(1);
            check_n("stall5_hold_round", int'(bus.rk_round), 5);
            check("stall5_hold_state", from_bytes(bus.state_out), from_bytes(mid));
        end
        bus.rk_valid = 1'b1;
        wait_idle(30);
        tick(2);

        // start while busy is ignored.
        start_enc(PT1, CT1, 1'b1, 0);
        tick(4);
        check_n("busy_start_round", int'(bus.rk_round), 4);
        start_enc(PTX, 128'h0, 1'b0, 0);
        wait_idle(20);
        tick(3);
        check_n("ignored_start_idle", int'(bus.busy), 0);

        // Reset mid-operation aborts with no done.
        start_enc(PT1, CT1, 1'b0, 0);
        tick(6);
        check_n("abort_round", int'(bus.rk_round), 6);
        rst = 1'b1;
        tick(1);
        check_reset_values("abort");
        rst = 1'b0;
        tick(3);
        check_n("abort_stays_idle", int'(bus.busy), 0);
        start_enc(PT1, CT1, 1'b1, 0);
        wait_idle(20);
        tick(2);

        // start held high: one encryption every 13 cycles.
        bus.text_in = to_bytes(PT1);
        bus.start   = 1'b1;
        for (int k = 0; k < 3; k++) begin
            exp_q.push_back(CT1);
            exp_cyc_q.push_back(cyc + 12 + 13 * k);
        end
        tick(30);
        bus.start = 1'b0;
        wait_idle(20);
        tick(5);

        check_n("sb_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
